// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - memory-side responder for the CPU datapath bus with wait states and loader port
// Each CPU request produces exactly one access and one ack pulse. The loader writes only while idle.
module cpu_mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] memaddr,
   input  logic [7:0]  data_in,
   input  logic        read,
   input  logic        write,
   output logic [7:0]  data_out,
   output logic        ack,
   output logic        err,
   output logic        busy,
   input  logic        load_we,
   input  logic [15:0] load_addr,
   input  logic [7:0]  load_data
);
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK, S_HOLD} state_t;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic [15:0]       addr_q;
   logic [7:0]        wdata_q;
   logic              rd_q;
   logic              wr_q;
   logic [7:0]        dout_q;
   logic              ack_q;
   logic              err_q;
   logic              busy_q;
   logic [7:0]        mem_q [2**ADDR_W];

   logic              addr_ok;
   logic              load_ok;
   logic              access_now;
   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_waddr_d;
   logic [7:0]        mem_wdata_d;

   // Upper address bits must be zero; shifting keeps this legal even when ADDR_W is 16.
   assign addr_ok    = (addr_q >> ADDR_W) == 16'd0;
   assign load_ok    = (load_addr >> ADDR_W) == 16'd0;
   assign access_now = (state_q == S_BUSY) && (cnt_q == 4'd0);

   always_comb begin
      mem_we_d    = 1'b0;
      mem_waddr_d = load_addr[ADDR_W-1:0];
      mem_wdata_d = load_data;
      if (rst) begin
         if (state_q == S_IDLE) begin
            mem_we_d = load_we && load_ok;
         end else if (access_now && wr_q && !rd_q && addr_ok) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = addr_q[ADDR_W-1:0];
            mem_wdata_d = wdata_q;
         end
      end
   end

   // The array has no reset: contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_we_d) begin
         mem_q[mem_waddr_d] <= mem_wdata_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 16'd0;
         wdata_q <= 8'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         dout_q  <= 8'h00;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               ack_q <= 1'b0;
               err_q <= 1'b0;
               if (!load_we && (read || write)) begin
                  addr_q  <= memaddr;
                  wdata_q <= data_in;
                  rd_q    <= read;
                  wr_q    <= write;
                  cnt_q   <= WAIT_INIT;
                  state_q <= S_BUSY;
                  busy_q  <= 1'b1;
               end
            end
            S_BUSY: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  state_q <= S_ACK;
                  ack_q   <= 1'b1;
                  if (rd_q && wr_q) begin
                     err_q <= 1'b1;
                  end else if (!addr_ok) begin
                     err_q <= 1'b1;
                     if (rd_q) begin
                        dout_q <= 8'h00;
                     end
                  end else if (rd_q) begin
                     dout_q <= mem_q[addr_q[ADDR_W-1:0]];
                  end
               end
            end
            S_ACK: begin
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               state_q <= S_HOLD;
            end
            S_HOLD: begin
               if (!read && !write) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
            end
         endcase
      end
   end

   assign data_out = dout_q;
   assign ack      = ack_q;
   assign err      = err_q;
   assign busy     = busy_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - self-checking bench for cpu_mem_responder
// Directed table, hand sequences and random transactions against a transaction-level memory model.
module tb_cpu_mem_responder;
   localparam int W = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic [15:0] memaddr = 16'd0;
   logic [7:0]  data_in = 8'd0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [7:0]  data_out;
   logic        ack, err, busy;
   logic        load_we = 1'b0;
   logic [15:0] load_addr = 16'd0;
   logic [7:0]  load_data = 8'd0;

   logic [15:0] memaddr0 = 16'd0;
   logic [7:0]  data_in0 = 8'd0;
   logic        read0 = 1'b0;
   logic        write0 = 1'b0;
   logic [7:0]  data_out0;
   logic        ack0, err0, busy0;
   logic        load_we0 = 1'b0;
   logic [15:0] load_addr0 = 16'd0;
   logic [7:0]  load_data0 = 8'd0;

   cpu_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .memaddr(memaddr), .data_in(data_in), .read(read), .write(write),
      .data_out(data_out), .ack(ack), .err(err), .busy(busy),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
   );

   cpu_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .memaddr(memaddr0), .data_in(data_in0), .read(read0), .write(write0),
      .data_out(data_out0), .ack(ack0), .err(err0), .busy(busy0),
      .load_we(load_we0), .load_addr(load_addr0), .load_data(load_data0)
   );

   int errors = 0;
   int checks = 0;
   logic [7:0] mem_m [256];
   logic [7:0] dout_m = 8'h00;

   typedef struct {
      logic [1:0]  op;      // 0 load, 1 read, 2 write, 3 read+write
      logic [15:0] addr;
      logic [7:0]  data;
      logic [7:0]  exp_dout;
      logic        exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [15:0] a, input logic [7:0] d);
      load_we = 1'b1; load_addr = a; load_data = d;
      @(posedge clk); #1;
      load_we = 1'b0;
      if (a[15:8] == 8'd0) mem_m[a[7:0]] = d;
   endtask

   task automatic model_access(input logic rd, input logic wr, input logic [15:0] a,
                               input logic [7:0] d, output logic [7:0] edout, output logic eerr);
      if (rd && wr) begin
         eerr = 1'b1;
      end else if (a[15:8] != 8'd0) begin
         eerr = 1'b1;
         if (rd) dout_m = 8'h00;
      end else begin
         eerr = 1'b0;
         if (rd) dout_m = mem_m[a[7:0]];
         else mem_m[a[7:0]] = d;
      end
      edout = dout_m;
   endtask

   task automatic cpu_op(input string tag, input logic rd, input logic wr, input logic [15:0] a,
                         input logic [7:0] d, input logic with_load, input logic [7:0] ld,
                         output logic [7:0] got_dout, output logic got_err);
      int n;
      int exp_n;
      logic got;
      logic [7:0] edout;
      logic eerr;
      if (with_load) begin
         load_we = 1'b1; load_addr = a; load_data = ld;
         if (a[15:8] == 8'd0) mem_m[a[7:0]] = ld;
      end
      read = rd; write = wr; memaddr = a; data_in = d;
      model_access(rd, wr, a, d, edout, eerr);
      exp_n = W + 2 + (with_load ? 1 : 0);
      n = 0; got = 1'b0;
      while (!got && n < 40) begin
         @(posedge clk); #1;
         n++;
         load_we = 1'b0;
         if (n == (with_load ? 2 : 1)) begin
            memaddr = 16'($urandom);
            data_in = 8'($urandom);
         end
         if (ack) got = 1'b1;
      end
      got_dout = data_out;
      got_err  = err;
      check({tag, " latency"}, 32'(n), 32'(exp_n));
      check({tag, " data_out"}, 32'(data_out), 32'(edout));
      check({tag, " err"}, 32'(err), 32'(eerr));
      check({tag, " busy at ack"}, 32'(busy), 32'd1);
      repeat (2) begin
         @(posedge clk); #1;
         check({tag, " hold ack"}, 32'(ack), 32'd0);
         check({tag, " hold err"}, 32'(err), 32'd0);
         check({tag, " hold busy"}, 32'(busy), 32'd1);
      end
      read = 1'b0; write = 1'b0;
      @(posedge clk); #1;
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      check({tag, " data_out kept"}, 32'(data_out), 32'(edout));
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [12];
      logic [7:0] gd;
      logic ge;
      int n;

      vecs[0]  = '{2'd0, 16'h0010, 8'hA5, 8'h00, 1'b0};
      vecs[1]  = '{2'd1, 16'h0010, 8'h00, 8'hA5, 1'b0};
      vecs[2]  = '{2'd2, 16'h0020, 8'h3C, 8'hA5, 1'b0};
      vecs[3]  = '{2'd1, 16'h0020, 8'h00, 8'h3C, 1'b0};
      vecs[4]  = '{2'd0, 16'h0034, 8'h5A, 8'h00, 1'b0};
      vecs[5]  = '{2'd1, 16'h1234, 8'h00, 8'h00, 1'b1};
      vecs[6]  = '{2'd2, 16'h0134, 8'h77, 8'h00, 1'b1};
      vecs[7]  = '{2'd1, 16'h0034, 8'h00, 8'h5A, 1'b0};
      vecs[8]  = '{2'd3, 16'h0034, 8'h99, 8'h5A, 1'b1};
      vecs[9]  = '{2'd1, 16'h0034, 8'h00, 8'h5A, 1'b0};
      vecs[10] = '{2'd0, 16'h1210, 8'hEE, 8'h00, 1'b0};
      vecs[11] = '{2'd1, 16'h0010, 8'h00, 8'hA5, 1'b0};

      #1;
      check("reset data_out", 32'(data_out), 32'h00);
      check("reset ack", 32'(ack), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset busy w0", 32'(busy0), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 256; i++) do_load(16'(i), 8'($urandom));

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].op == 2'd0) begin
            do_load(vecs[i].addr, vecs[i].data);
         end else begin
            cpu_op($sformatf("vec%0d", i), vecs[i].op[0], vecs[i].op[1], vecs[i].addr,
                   vecs[i].data, 1'b0, 8'h00, gd, ge);
            check($sformatf("vec%0d table dout", i), 32'(gd), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d table err", i), 32'(ge), 32'(vecs[i].exp_err));
         end
      end

      // Load and read in the same idle cycle: the read sees the freshly loaded byte, one cycle late.
      cpu_op("load+read", 1'b1, 1'b0, 16'h0050, 8'h00, 1'b1, 8'hC7, gd, ge);
      check("load+read value", 32'(gd), 32'hC7);

      // Reset in the middle of a write aborts it.
      do_load(16'h0040, 8'h11);
      write = 1'b1; memaddr = 16'h0040; data_in = 8'h99;
      @(posedge clk); #1;
      check("abort busy before reset", 32'(busy), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort ack", 32'(ack), 32'd0);
      check("abort data_out", 32'(data_out), 32'h00);
      dout_m = 8'h00;
      write = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      cpu_op("after abort", 1'b1, 1'b0, 16'h0040, 8'h00, 1'b0, 8'h00, gd, ge);
      check("after abort value", 32'(gd), 32'h11);

      // Zero wait-state build.
      load_we0 = 1'b1; load_addr0 = 16'h0005; load_data0 = 8'hC3;
      @(posedge clk); #1;
      load_we0 = 1'b0; read0 = 1'b1; memaddr0 = 16'h0005;
      n = 0;
      while (!ack0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("w0 latency", 32'(n), 32'd2);
      check("w0 data_out", 32'(data_out0), 32'hC3);
      check("w0 err", 32'(err0), 32'd0);
      read0 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("w0 idle busy", 32'(busy0), 32'd0);

      for (int i = 0; i < 60; i++) begin
         logic [15:0] a;
         int kind;
         a = 16'($urandom_range(0, 255));
         if ($urandom_range(0, 5) == 0) a[15:8] = 8'($urandom_range(1, 255));
         kind = $urandom_range(0, 9);
         if (kind < 2) begin
            do_load(a, 8'($urandom));
         end else begin
            cpu_op($sformatf("rnd%0d", i), kind < 6 || kind == 9, kind >= 6,
                   a, 8'($urandom), $urandom_range(0, 7) == 0, 8'($urandom), gd, ge);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
